// File: rtl/pipe_hazard_unit_if.sv
// ID-side hazard bus: decode fields and RF/forwarding data in, resolved operands and control out.
interface pipe_hazard_unit_if #(
  parameter int DSIZE      = 16,
  parameter int RSIZE      = 4,
  parameter int PIPE_DEPTH = 3,
  parameter int SEL_W      = $clog2(PIPE_DEPTH+1)
);
  logic                        id_valid;
  logic                        id_wen;
  logic                        id_is_load;
  logic [RSIZE-1:0]            id_waddr;
  logic                        id_ren1;
  logic                        id_ren2;
  logic [RSIZE-1:0]            id_raddr1;
  logic [RSIZE-1:0]            id_raddr2;
  logic                        flush;
  logic [DSIZE-1:0]            rf_data1;
  logic [DSIZE-1:0]            rf_data2;
  logic [PIPE_DEPTH*DSIZE-1:0] fwd_data;
  logic [DSIZE-1:0]            op1;
  logic [DSIZE-1:0]            op2;
  logic [SEL_W-1:0]            fwd_sel1;
  logic [SEL_W-1:0]            fwd_sel2;
  logic                        stall;
  logic                        issue;

  modport master (
    output id_valid, id_wen, id_is_load, id_waddr, id_ren1, id_ren2,
           id_raddr1, id_raddr2, flush, rf_data1, rf_data2, fwd_data,
    input  op1, op2, fwd_sel1, fwd_sel2, stall, issue
  );

  modport slave (
    input  id_valid, id_wen, id_is_load, id_waddr, id_ren1, id_ren2,
           id_raddr1, id_raddr2, flush, rf_data1, rf_data2, fwd_data,
    output op1, op2, fwd_sel1, fwd_sel2, stall, issue
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: tracks in-flight writers, forwards operands, raises load-use stall.

// Per-operand resolver: picks the youngest in-flight writer of raddr.
module pipe_hazard_operand #(
  parameter int DSIZE      = 16,
  parameter int RSIZE      = 4,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_READY = 2,
  parameter int ZERO_REG   = 1,
  parameter int SEL_W      = 2
) (
  input  logic                             ren,
  input  logic [RSIZE-1:0]                 raddr,
  input  logic [DSIZE-1:0]                 rf_data,
  input  logic [PIPE_DEPTH*DSIZE-1:0]      fwd_data,
  input  logic [PIPE_DEPTH-1:0]            s_valid,
  input  logic [PIPE_DEPTH-1:0]            s_wen,
  input  logic [PIPE_DEPTH-1:0]            s_load,
  input  logic [PIPE_DEPTH-1:0][RSIZE-1:0] s_waddr,
  output logic [SEL_W-1:0]                 sel,
  output logic [DSIZE-1:0]                 op,
  output logic                             load_hz
);
  logic zero_src;
  assign zero_src = (ZERO_REG != 0) && (raddr == '0);

  // Scan oldest to youngest so the youngest hit is the one left standing.
  always_comb begin
    sel     = '0;
    op      = rf_data;
    load_hz = 1'b0;
    for (int k = PIPE_DEPTH-1; k >= 0; k--) begin
      if (ren && !zero_src && s_valid[k] && s_wen[k] && s_waddr[k] == raddr) begin
        sel     = SEL_W'(k+1);
        op      = fwd_data[k*DSIZE +: DSIZE];
        load_hz = s_load[k] && (k < LOAD_READY);
      end
    end
  end
endmodule

module pipe_hazard_unit #(
  parameter int DSIZE      = 16,
  parameter int RSIZE      = 4,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_READY = 2,
  parameter int ZERO_REG   = 1,
  parameter int SEL_W      = $clog2(PIPE_DEPTH+1),
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_hazard_unit_if.slave     hz,
  output logic [PIPE_DEPTH-1:0] stg_valid,
  output logic [CNT_W-1:0]      stall_cnt
);
  typedef struct packed {
    logic             valid;
    logic             wen;
    logic             is_load;
    logic [RSIZE-1:0] waddr;
  } stg_t;

  stg_t [PIPE_DEPTH-1:0]            stg;
  stg_t                             stg0_nxt;
  logic [PIPE_DEPTH-1:0]            s_valid, s_wen, s_load;
  logic [PIPE_DEPTH-1:0][RSIZE-1:0] s_waddr;
  logic [1:0]                       ren;
  logic [1:0][RSIZE-1:0]            raddr;
  logic [1:0][DSIZE-1:0]            rf_data, op;
  logic [1:0][SEL_W-1:0]            sel;
  logic [1:0]                       load_hz;
  logic                             stall, issue;

  genvar k, o;
  for (k = 0; k < PIPE_DEPTH; k++) begin : g_stg
    assign s_valid[k] = stg[k].valid;
    assign s_wen[k]   = stg[k].wen;
    assign s_load[k]  = stg[k].is_load;
    assign s_waddr[k] = stg[k].waddr;
  end

  assign ren     = {hz.id_ren2,   hz.id_ren1};
  assign raddr   = {hz.id_raddr2, hz.id_raddr1};
  assign rf_data = {hz.rf_data2,  hz.rf_data1};

  for (o = 0; o < 2; o++) begin : g_opnd
    pipe_hazard_operand #(
      .DSIZE(DSIZE), .RSIZE(RSIZE), .PIPE_DEPTH(PIPE_DEPTH),
      .LOAD_READY(LOAD_READY), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W)
    ) u_opnd (
      .ren(ren[o]), .raddr(raddr[o]), .rf_data(rf_data[o]), .fwd_data(hz.fwd_data),
      .s_valid(s_valid), .s_wen(s_wen), .s_load(s_load), .s_waddr(s_waddr),
      .sel(sel[o]), .op(op[o]), .load_hz(load_hz[o])
    );
  end

  // Flush outranks the load-use interlock: a killed instruction never stalls.
  assign stall = hz.id_valid && !hz.flush && (|load_hz);
  assign issue = hz.id_valid && !hz.flush && !stall;

  assign hz.stall    = stall;
  assign hz.issue    = issue;
  assign hz.op1      = op[0];
  assign hz.op2      = op[1];
  assign hz.fwd_sel1 = sel[0];
  assign hz.fwd_sel2 = sel[1];
  assign stg_valid   = s_valid;

  // Stage 0 takes the ID instruction only when it issues; otherwise a bubble.
  always_comb begin
    stg0_nxt = '0;
    if (issue) begin
      stg0_nxt.valid   = 1'b1;
      stg0_nxt.wen     = hz.id_wen;
      stg0_nxt.is_load = hz.id_is_load;
      stg0_nxt.waddr   = hz.id_waddr;
    end
  end

  // Downstream stages never stall: shift every edge, last stage retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg <= '0;
    end else begin
      stg[0] <= stg0_nxt;
      for (int i = 1; i < PIPE_DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      stall_cnt <= '0;
    else if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench: directed table, hand sequences, random vs. in-flight-list model, saturation.
module tb_pipe_hazard_unit;
  localparam int D  = 3;
  localparam int LR = 2;

  logic clk, rst;
  logic [D-1:0]  stg_valid;
  logic [15:0]   stall_cnt;
  logic [7:0]    stg_valid2;
  logic [15:0]   stall_cnt2;

  pipe_hazard_unit_if #(.DSIZE(16), .RSIZE(4), .PIPE_DEPTH(D)) bus ();
  pipe_hazard_unit_if #(.DSIZE(16), .RSIZE(4), .PIPE_DEPTH(8)) bus2 ();

  pipe_hazard_unit #(.DSIZE(16), .RSIZE(4), .PIPE_DEPTH(D), .LOAD_READY(LR), .ZERO_REG(1), .CNT_W(16))
    dut (.clk(clk), .rst(rst), .hz(bus), .stg_valid(stg_valid), .stall_cnt(stall_cnt));

  // Deep pipe where a load waits 7 stages: keeps the stall counter busy for the saturation run.
  pipe_hazard_unit #(.DSIZE(16), .RSIZE(4), .PIPE_DEPTH(8), .LOAD_READY(7), .ZERO_REG(1), .CNT_W(16))
    dut2 (.clk(clk), .rst(rst), .hz(bus2), .stg_valid(stg_valid2), .stall_cnt(stall_cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: list of in-flight instructions, youngest first
  typedef struct { bit v; bit w; bit l; bit [3:0] a; } ent_t;
  typedef struct packed { bit [1:0] s1; bit [1:0] s2; bit [15:0] o1; bit [15:0] o2; bit st; bit is; } res_t;
  ent_t m[D];
  int   mstalls;

  function automatic void pick(input bit ren, input bit [3:0] a, input bit [15:0] rf,
                               output bit [1:0] sel, output bit [15:0] op, output bit hzd);
    sel = 0; op = rf; hzd = 0;
    if (ren && a != 0) begin
      for (int k = 0; k < D; k++) begin
        if (m[k].v && m[k].w && m[k].a == a) begin
          sel = 2'(k+1);
          op  = bus.fwd_data[k*16 +: 16];
          hzd = m[k].l && (k < LR);
          break;
        end
      end
    end
  endfunction

  function automatic res_t model_eval();
    res_t r;
    bit h1, h2;
    pick(bus.id_ren1, bus.id_raddr1, bus.rf_data1, r.s1, r.o1, h1);
    pick(bus.id_ren2, bus.id_raddr2, bus.rf_data2, r.s2, r.o2, h2);
    r.st = bus.id_valid && !bus.flush && (h1 || h2);
    r.is = bus.id_valid && !bus.flush && !r.st;
    return r;
  endfunction

  // Model advances on the same edges as the DUT, from the same ID inputs.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < D; k++) m[k] <= '{0, 0, 0, 4'd0};
      mstalls <= 0;
    end else begin
      res_t r;
      r = model_eval();
      for (int k = D-1; k > 0; k--) m[k] <= m[k-1];
      if (r.is) m[0] <= '{1'b1, bus.id_wen, bus.id_is_load, bus.id_waddr};
      else      m[0] <= '{0, 0, 0, 4'd0};
      if (r.st) mstalls <= mstalls + 1;
    end
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_id(input bit v, input bit w, input bit l, input bit [3:0] wa,
                        input bit r1, input bit [3:0] a1, input bit r2, input bit [3:0] a2, input bit f);
    bus.id_valid = v; bus.id_wen = w; bus.id_is_load = l; bus.id_waddr = wa;
    bus.id_ren1 = r1; bus.id_raddr1 = a1; bus.id_ren2 = r2; bus.id_raddr2 = a2; bus.flush = f;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (D) tick();
  endtask

  typedef struct {
    bit pw; bit pl; bit [3:0] pa; int gap;
    bit cv; bit r1; bit [3:0] a1; bit r2; bit [3:0] a2; bit fl;
    bit [1:0] s1; bit [1:0] s2; bit st; bit is;
  } vec_t;
  vec_t tbl[13];

  initial begin
    res_t r;
    bit [15:0] eo1, eo2;
    // producer (wen,load,reg,stage) | consumer (valid,ren1,r1,ren2,r2,flush) | sel1 sel2 stall issue
    tbl[0]  = '{1,0,4'd3,0, 1,1,4'd3,0,4'd3,0, 2'd1,2'd0,0,1};
    tbl[1]  = '{1,0,4'd3,1, 1,0,4'd0,1,4'd3,0, 2'd0,2'd2,0,1};
    tbl[2]  = '{1,0,4'd3,2, 1,1,4'd3,0,4'd0,0, 2'd3,2'd0,0,1};
    tbl[3]  = '{1,1,4'd5,0, 1,1,4'd5,0,4'd0,0, 2'd1,2'd0,1,0};
    tbl[4]  = '{1,1,4'd5,1, 1,0,4'd0,1,4'd5,0, 2'd0,2'd2,1,0};
    tbl[5]  = '{1,1,4'd5,2, 1,1,4'd5,0,4'd0,0, 2'd3,2'd0,0,1};
    tbl[6]  = '{1,0,4'd0,0, 1,1,4'd0,1,4'd0,0, 2'd0,2'd0,0,1};
    tbl[7]  = '{1,0,4'd3,0, 1,0,4'd3,0,4'd3,0, 2'd0,2'd0,0,1};
    tbl[8]  = '{1,1,4'd5,0, 1,1,4'd5,0,4'd0,1, 2'd1,2'd0,0,0};
    tbl[9]  = '{0,0,4'd3,0, 1,1,4'd3,1,4'd3,0, 2'd0,2'd0,0,1};
    tbl[10] = '{1,0,4'd4,0, 1,1,4'd3,1,4'd4,0, 2'd0,2'd1,0,1};
    tbl[11] = '{1,1,4'd5,0, 0,1,4'd5,0,4'd0,0, 2'd1,2'd0,0,0};
    tbl[12] = '{1,1,4'd5,1, 1,1,4'd5,1,4'd5,0, 2'd2,2'd2,1,0};

    for (int k = 0; k < D; k++) m[k] = '{0, 0, 0, 4'd0};
    mstalls = 0;
    rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.rf_data1 = 16'hAAAA; bus.rf_data2 = 16'h5555;
    bus.fwd_data = {16'h3333, 16'h2222, 16'h1111};
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus2.id_valid = 0; bus2.id_wen = 0; bus2.id_is_load = 0; bus2.id_waddr = 0;
    bus2.id_ren1 = 0; bus2.id_raddr1 = 0; bus2.id_ren2 = 0; bus2.id_raddr2 = 0; bus2.flush = 0;
    bus2.rf_data1 = 0; bus2.rf_data2 = 0; bus2.fwd_data = '0;

    // Reset state
    #1;
    check("rst_ctl", 64'({bus.stall, bus.issue, bus.fwd_sel1, bus.fwd_sel2}), 64'd0);
    check("rst_op", 64'({bus.op1, bus.op2}), 64'({16'hAAAA, 16'h5555}));
    check("rst_state", 64'({stg_valid, stall_cnt}), 64'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Back-to-back ALU forward
    bus.fwd_data = {16'h3333, 16'h2222, 16'h1234};
    set_id(1, 1, 0, 3, 0, 0, 0, 0, 0); tick();
    set_id(1, 1, 0, 7, 1, 3, 0, 0, 0); #1;
    check("b2b_alu", 64'({bus.fwd_sel1, bus.op1, bus.stall}), 64'({2'd1, 16'h1234, 1'b0}));
    drain();

    // Load-use: load stays unforwardable until it reaches stage LOAD_READY
    bus.fwd_data = {16'hBEEF, 16'h2222, 16'h1111};
    set_id(1, 1, 1, 5, 0, 0, 0, 0, 0); tick();
    set_id(1, 1, 0, 6, 1, 5, 0, 0, 0); #1;
    check("lu_c0", 64'({bus.stall, bus.issue, bus.fwd_sel1}), 64'({1'b1, 1'b0, 2'd1}));
    tick();
    check("lu_c1", 64'({stg_valid[0], bus.stall, bus.fwd_sel1, stall_cnt}), 64'({1'b0, 1'b1, 2'd2, 16'd1}));
    tick();
    check("lu_c2", 64'({bus.stall, bus.issue, bus.fwd_sel1, bus.op1, stall_cnt}),
          64'({1'b0, 1'b1, 2'd3, 16'hBEEF, 16'd2}));
    drain();

    // Youngest producer wins
    bus.fwd_data = {16'h0002, 16'h0777, 16'h0001};
    set_id(1, 1, 0, 2, 0, 0, 0, 0, 0); tick();
    set_id(1, 1, 0, 7, 0, 0, 0, 0, 0); tick();
    set_id(1, 1, 0, 2, 0, 0, 0, 0, 0); tick();
    set_id(1, 0, 0, 0, 1, 2, 1, 7, 0); #1;
    check("youngest", 64'({bus.fwd_sel1, bus.op1, bus.fwd_sel2, bus.op2}),
          64'({2'd1, 16'h0001, 2'd2, 16'h0777}));
    drain();

    // Flush during load-use
    set_id(1, 1, 1, 5, 0, 0, 0, 0, 0); tick();
    set_id(1, 1, 0, 6, 1, 5, 0, 0, 1); #1;
    check("flush_ctl", 64'({bus.stall, bus.issue}), 64'd0);
    tick();
    check("flush_bubble", 64'(stg_valid), 64'(3'b010));
    drain();

    // Directed table
    bus.fwd_data = {16'h3333, 16'h2222, 16'h1111};
    for (int i = 0; i < 13; i++) begin
      drain();
      set_id(1, tbl[i].pw, tbl[i].pl, tbl[i].pa, 0, 0, 0, 0, 0); tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (tbl[i].gap) tick();
      set_id(tbl[i].cv, 1, 0, 9, tbl[i].r1, tbl[i].a1, tbl[i].r2, tbl[i].a2, tbl[i].fl); #1;
      eo1 = (tbl[i].s1 == 0) ? 16'hAAAA : 16'(16'h1111 * tbl[i].s1);
      eo2 = (tbl[i].s2 == 0) ? 16'h5555 : 16'(16'h1111 * tbl[i].s2);
      check($sformatf("tbl%0d", i),
            64'({bus.fwd_sel1, bus.fwd_sel2, bus.stall, bus.issue, bus.op1, bus.op2}),
            64'({tbl[i].s1, tbl[i].s2, tbl[i].st, tbl[i].is, eo1, eo2}));
    end
    drain();

    // Async reset mid-stall
    set_id(1, 1, 0, 3, 0, 0, 0, 0, 0); tick();
    set_id(1, 1, 1, 5, 0, 0, 0, 0, 0); tick();
    set_id(1, 1, 0, 6, 1, 5, 0, 0, 0); tick();
    #1 rst = 1'b0;
    #1;
    check("arst", 64'({stg_valid, stall_cnt, bus.stall, bus.issue}), 64'({3'b000, 16'd0, 1'b0, 1'b1}));
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();

    // Random against the model
    for (int n = 0; n < 3000; n++) begin
      set_id($urandom_range(3) != 0, $urandom_range(1), $urandom_range(2) == 0, 4'($urandom_range(7)),
             $urandom_range(3) != 0, 4'($urandom_range(7)), $urandom_range(3) != 0,
             4'($urandom_range(7)), $urandom_range(7) == 0);
      bus.rf_data1 = 16'($urandom); bus.rf_data2 = 16'($urandom);
      bus.fwd_data = {16'($urandom), 16'($urandom), 16'($urandom)};
      #1;
      r = model_eval();
      check("rnd_out", 64'({bus.fwd_sel1, bus.fwd_sel2, bus.op1, bus.op2, bus.stall, bus.issue}), 64'(r));
      check("rnd_state", 64'({stg_valid, stall_cnt}),
            64'({m[2].v, m[1].v, m[0].v, 16'(mstalls > 65535 ? 65535 : mstalls)}));
      tick();
    end
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Saturation: a load that reads its own destination stalls 7 of every 8 cycles
    bus2.id_valid = 1; bus2.id_wen = 1; bus2.id_is_load = 1; bus2.id_waddr = 5;
    bus2.id_ren1 = 1; bus2.id_raddr1 = 5;
    repeat (76000) @(posedge clk);
    #2;
    check("sat_cnt", 64'(stall_cnt2), 64'(16'hFFFF));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
